// File: rtl/scd_pkg.sv
// scd_pkg: shared states, counter operations and constants for the SCD shift-count sequencer.
package scd_pkg;
  localparam int SC_W = 10;
  localparam int MAX_NORM = 36;
  localparam logic [2:0] DIAG_FUNC = 3'b101;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, STEP = 2'd2, DONE = 2'd3} state_e;
  typedef enum logic [1:0] {SC_HOLD, SC_LOAD, SC_INC, SC_DEC} sc_op_e;
endpackage

// File: rtl/scd_sc_counter.sv
// scd_sc_counter: SC register with load/increment/decrement/hold and its sign and zero flags.
module scd_sc_counter import scd_pkg::*; (
  input  logic            clk,
  input  logic            reset_n,
  input  sc_op_e          op_i,
  input  logic [0:SC_W-1] load_i,
  output logic [0:SC_W-1] sc_o,
  output logic            sign_o,
  output logic            eq0_o
);
  logic [0:SC_W-1] sc_d, sc_q;
  always_comb sc_d = op_i == SC_LOAD ? load_i :
                     op_i == SC_INC  ? sc_q + SC_W'(1) :
                     op_i == SC_DEC  ? sc_q - SC_W'(1) : sc_q;
  always_ff @(posedge clk)
    if (!reset_n) sc_q <= '0;
    else sc_q <= sc_d;
  assign sc_o   = sc_q;
  assign sign_o = sc_q[0];
  assign eq0_o  = sc_q == '0;
endmodule

// File: rtl/scd_shift_seq.sv
// scd_shift_seq: sequences counted AR shifts and normalize loops on the SC counter.
// Optional EBUS diagnostic readback is enabled by defining SCD_SEQ_DIAG_EN.
module scd_shift_seq import scd_pkg::*; (
  input  logic            clk,
  input  logic            reset_n,
`ifdef SCD_SEQ_DIAG_EN
  input  logic [4:6]      DIAG,
  input  logic            DIAG_READ_FUNC_13X,
  output logic            drivingEBUS,
  output logic [0:35]     ebusOut,
`endif
  input  logic            start,
  input  logic            mode,
  input  logic [0:SC_W-1] count,
  input  logic            ar_norm,
  input  logic            abort,
  output logic            busy,
  output logic            step,
  output logic            step_right,
  output logic            done,
  output logic            norm_fail,
  output logic [0:SC_W-1] SC,
  output logic            SCsign,
  output logic            SCeq0
);
  state_e          state_q;
  logic            mode_q, right_q, nf_q;
  sc_op_e          sc_op;
  logic [0:SC_W-1] sc_load;
  logic            sc_last, sc_max;
  // sc_last: the step about to be taken brings a counted shift to zero
  always_comb begin
    sc_max  = SC == SC_W'(MAX_NORM);
    sc_last = right_q ? &SC : SC == SC_W'(1);
    step    = state_q == STEP && !abort && (!mode_q || (!ar_norm && !sc_max));
    sc_load = mode ? '0 : count;
    sc_op   = SC_HOLD;
    if (state_q == IDLE && start && !abort) sc_op = SC_LOAD;
    else if (step && (mode_q || right_q)) sc_op = SC_INC;
    else if (step) sc_op = SC_DEC;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      right_q <= 1'b0;
      nf_q    <= 1'b0;
    end else begin
      nf_q <= 1'b0;
      case (state_q)
        IDLE: if (start && !abort) begin
          state_q <= LOAD;
          mode_q  <= mode;
        end
        LOAD: if (abort) state_q <= IDLE;
        else begin
          right_q <= !mode_q && SC[0];
          if (!mode_q && SCeq0) state_q <= DONE;
          else state_q <= STEP;
        end
        STEP: if (abort) state_q <= IDLE;
        else if (mode_q) begin
          if (ar_norm || sc_max) begin
            state_q <= DONE;
            nf_q    <= !ar_norm;
          end
        end else if (sc_last) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  assign busy       = state_q == LOAD || state_q == STEP;
  assign done       = state_q == DONE;
  assign norm_fail  = nf_q;
  assign step_right = right_q;
  scd_sc_counter u_sc (
    .clk    (clk),
    .reset_n(reset_n),
    .op_i   (sc_op),
    .load_i (sc_load),
    .sc_o   (SC),
    .sign_o (SCsign),
    .eq0_o  (SCeq0)
  );
`ifdef SCD_SEQ_DIAG_EN
  assign drivingEBUS = DIAG_READ_FUNC_13X && DIAG == DIAG_FUNC;
  assign ebusOut = drivingEBUS ? {1'b0, state_q, mode_q, right_q, {(31-SC_W){1'b0}}, SC} : '0;
`endif
endmodule

// File: tb/tb_scd_shift_seq.sv
// tb_scd_shift_seq: randomized bench for scd_shift_seq against an operation-level reference model.
module tb_scd_shift_seq;
  logic clk = 0, reset_n = 0, start = 0, mode = 0, ar_norm = 0, abort = 0;
  logic [0:9] count = '0;
  logic busy, step, step_right, done, norm_fail, SCsign, SCeq0;
  logic [0:9] SC;
`ifdef SCD_SEQ_DIAG_EN
  logic [4:6] DIAG = '0;
  logic DIAG_READ_FUNC_13X = 0;
  logic drivingEBUS;
  logic [0:35] ebusOut;
`endif
  int n_chk = 0, n_fail = 0, cyc = 0, t0 = 0, nsteps = 0, done_dt = -1;
  logic [0:9] done_sc = '0;
  logic done_nf = 0, last_sr = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  scd_shift_seq dut (
    .clk(clk), .reset_n(reset_n),
`ifdef SCD_SEQ_DIAG_EN
    .DIAG(DIAG), .DIAG_READ_FUNC_13X(DIAG_READ_FUNC_13X), .drivingEBUS(drivingEBUS), .ebusOut(ebusOut),
`endif
    .start(start), .mode(mode), .count(count), .ar_norm(ar_norm), .abort(abort),
    .busy(busy), .step(step), .step_right(step_right), .done(done), .norm_fail(norm_fail),
    .SC(SC), .SCsign(SCsign), .SCeq0(SCeq0)
  );

  task automatic chk(input string nm, input logic [35:0] a, input logic [35:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, a, e);
    end
  endtask

  // Reference model: one accepted operation, tracked by cycles since start (k),
  // steps taken (sh) and the cycle on which done is due (dk).
  bit act = 0, md = 0, sr_m = 0, nf_m = 0;
  int k = 0, dk = 0, sh = 0, n = 0;
  logic [0:9] sc_m = '0;
  always @(negedge clk) begin
    bit e_busy, e_step, e_done, e_nf;
    e_busy = 0; e_step = 0; e_done = 0; e_nf = 0;
    if (act) begin
      if (k == dk) begin
        e_done = 1;
        e_nf = nf_m;
      end else begin
        e_busy = 1;
        e_step = k >= 2 && !abort && (!md || (!ar_norm && sh < 36));
      end
    end
    if (chk_en) begin
      chk("busy", busy, e_busy);
      chk("step", step, e_step);
      chk("done", done, e_done);
      chk("norm_fail", norm_fail, e_nf);
      chk("step_right", step_right, sr_m);
      chk("SC", SC, sc_m);
      chk("SCsign", SCsign, sc_m[0]);
      chk("SCeq0", SCeq0, sc_m == 0);
    end
    if (!reset_n) begin
      act = 0; sc_m = '0; sr_m = 0; nf_m = 0;
    end else if (!act) begin
      if (start && !abort) begin
        act = 1; k = 1; md = mode; sh = 0; nf_m = 0;
        sc_m = mode ? 10'd0 : count;
        n = $signed(count);
        if (n < 0) n = -n;
        dk = mode ? 0 : n + 2;
      end
    end else if (k == dk || abort) act = 0;
    else begin
      if (k == 1) sr_m = !md && sc_m[0];
      if (e_step) begin
        sc_m = (md || sr_m) ? sc_m + 10'd1 : sc_m - 10'd1;
        sh++;
      end else if (md && k >= 2) begin
        dk = k + 1;
        nf_m = !ar_norm;
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (step) begin
      nsteps++;
      last_sr = step_right;
    end
    if (done) begin
      done_dt = cyc - t0;
      done_sc = SC;
      done_nf = norm_fail;
    end
  end

  // Launch one operation; *_at fire ar_norm / abort / extra start / reset once the step count reaches them (-1 = never).
  task automatic op(input bit m, input logic [0:9] c, input int ar_at, input int ab_at, input int st_at, input int rs_at);
    int post;
    bit afired, sfired, rfired;
    post = 0; afired = 0; sfired = 0; rfired = 0;
    start = 1; mode = m; count = c; nsteps = 0; done_dt = -1; t0 = cyc;
    @(posedge clk); #1;
    start = 0; mode = 1'($urandom); count = 10'($urandom);
    for (int i = 0; i < 700 && post < 2; i++) begin
      ar_norm = ar_at >= 0 && nsteps >= ar_at;
      abort = !afired && ab_at >= 0 && nsteps == ab_at;
      start = !sfired && st_at >= 0 && nsteps == st_at;
      reset_n = !(!rfired && rs_at >= 0 && nsteps == rs_at);
      afired |= abort; sfired |= start; rfired |= !reset_n;
      @(posedge clk); #1;
      if (done_dt >= 0 || afired || rfired) post++;
    end
    chk("op_ended", post >= 2, 1);
    start = 0; abort = 0; ar_norm = 0; reset_n = 1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1; chk_en = 1;
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_step", step, 0); chk("rst_done", done, 0);
    chk("rst_SC", SC, 0); chk("rst_SCeq0", SCeq0, 1);
    @(posedge clk); #1;
    op(0, 10'd5, -1, -1, -1, -1);
    chk("cnt5_steps", nsteps, 5); chk("cnt5_dt", done_dt, 7); chk("cnt5_sc", done_sc, 0); chk("cnt5_dir", last_sr, 0);
    op(0, 10'h3FD, -1, -1, -1, -1);
    chk("cntm3_steps", nsteps, 3); chk("cntm3_dt", done_dt, 5); chk("cntm3_dir", last_sr, 1);
    op(0, 10'd0, -1, -1, -1, -1);
    chk("cnt0_steps", nsteps, 0); chk("cnt0_dt", done_dt, 2);
    op(1, 10'd0, 4, -1, -1, -1);
    chk("norm4_steps", nsteps, 4); chk("norm4_sc", done_sc, 4); chk("norm4_nf", done_nf, 0); chk("norm4_dt", done_dt, 7);
    op(1, 10'd0, -1, -1, -1, -1);
    chk("normfail_steps", nsteps, 36); chk("normfail_sc", done_sc, 36); chk("normfail_nf", done_nf, 1);
    op(0, 10'd10, -1, 3, -1, -1);
    @(negedge clk);
    chk("abort_steps", nsteps, 3); chk("abort_nodone", done_dt, -1); chk("abort_sc", SC, 7); chk("abort_busy", busy, 0);
    @(posedge clk); #1;
    op(0, 10'd4, -1, -1, 2, -1);
    chk("restart_steps", nsteps, 4); chk("restart_dt", done_dt, 6);
    op(0, 10'd20, -1, -1, -1, 5);
    @(negedge clk);
    chk("rstmid_busy", busy, 0); chk("rstmid_step", step, 0); chk("rstmid_sc", SC, 0); chk("rstmid_sr", step_right, 0);
    @(posedge clk); #1;
    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    @(negedge clk);
    chk("startabort_busy", busy, 0);
    @(posedge clk); #1;
    op(0, 10'h200, -1, -1, -1, -1);
    chk("m512_steps", nsteps, 512); chk("m512_dt", done_dt, 514); chk("m512_dir", last_sr, 1);
`ifdef SCD_SEQ_DIAG_EN
    DIAG = 3'b101; DIAG_READ_FUNC_13X = 1; start = 1; mode = 0; count = 10'd2;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("diag_ebus", ebusOut, 36'o200000000002); chk("diag_drv", drivingEBUS, 1);
    DIAG = 3'b100;
    #1 chk("diag_other_drv", drivingEBUS, 0); chk("diag_other_ebus", ebusOut, 0);
    DIAG_READ_FUNC_13X = 0;
    repeat (4) @(posedge clk);
    #1;
`endif
    for (int r = 0; r < 200; r++) begin
      logic [0:9] c;
      int v, ar, ab, st, rs;
      v = $urandom_range(0, 40);
      if ($urandom_range(0, 1) == 1) v = -v;
      c = 10'(v);
      if ($urandom_range(0, 24) == 0) c = 10'($urandom);
      ar = $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, 40));
      ab = $urandom_range(0, 5) == 0 ? int'($urandom_range(0, 20)) : -1;
      st = $urandom_range(0, 5) == 0 ? int'($urandom_range(0, 20)) : -1;
      rs = $urandom_range(0, 15) == 0 ? int'($urandom_range(0, 20)) : -1;
      op(1'($urandom_range(0, 1)), c, ar, ab, st, rs);
      repeat ($urandom_range(0, 2)) begin
        start = 1'($urandom); abort = 1;
        @(posedge clk); #1;
      end
      start = 0; abort = 0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
